// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
// Holds the state and owner encodings, default widths and the grant-to-owner helper.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CORE = 2'b01,
    OWN_LOAD = 2'b10
  } owner_t;

  function automatic owner_t grant_to_owner(input logic [1:0] grant);
    owner_t result;
    case (grant)
      2'b01:   result = OWN_CORE;
      2'b10:   result = OWN_LOAD;
      default: result = OWN_NONE;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-request round-robin tie-break; bit 0 is the core, bit 1 the loader.
// The last-served flag comes out of reset pointing at the loader.
module arb_rr2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_load_r;

  // On a tie, grant whichever requester was not served last
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_load_r ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember who was granted on each entry to ISSUE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_load_r <= 1'b1;
    end else if (update) begin
      last_load_r <= grant[1];
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a core and a loader onto one single-port memory, one access per three cycles.
// mem_rdata arrives in RESP and is steered combinationally to the owner's rdata.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_ready,
  input  logic                  load_req,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_wdata,
  output logic [DATA_WIDTH-1:0] load_rdata,
  output logic                  load_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            owner
);

  state_t                state_r;
  state_t                state_next_s;
  owner_t                owner_r;
  logic                  lat_we_r;
  logic                  mem_en_r;
  logic                  mem_we_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  core_ready_r;
  logic                  load_ready_r;
  logic [1:0]            req_s;
  logic [1:0]            grant_s;
  logic                  take_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  assign req_s  = {load_req, core_req};
  assign take_s = (state_r == ST_IDLE) && (req_s != 2'b00);

  arb_rr2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    (req_s),
    .update (take_s),
    .grant  (grant_s)
  );

  assign sel_we_s    = grant_s[1] ? load_we    : core_we;
  assign sel_addr_s  = grant_s[1] ? load_addr  : core_addr;
  assign sel_wdata_s = grant_s[1] ? load_wdata : core_wdata;

  // Next-state: IDLE waits for a request, ISSUE and RESP each last one cycle
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = take_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_next_s = ST_RESP;
      ST_RESP:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs: mem strobe during ISSUE, ready pulse during RESP, owner outside IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_r      <= OWN_NONE;
      lat_we_r     <= 1'b0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      core_ready_r <= 1'b0;
      load_ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            owner_r     <= grant_to_owner(grant_s);
            lat_we_r    <= sel_we_s;
            mem_en_r    <= 1'b1;
            mem_we_r    <= sel_we_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
          end
        end
        ST_ISSUE: begin
          mem_en_r     <= 1'b0;
          mem_we_r     <= 1'b0;
          mem_addr_r   <= '0;
          mem_wdata_r  <= '0;
          core_ready_r <= (owner_r == OWN_CORE);
          load_ready_r <= (owner_r == OWN_LOAD);
        end
        ST_RESP: begin
          core_ready_r <= 1'b0;
          load_ready_r <= 1'b0;
          owner_r      <= OWN_NONE;
          lat_we_r     <= 1'b0;
        end
        default: begin
          owner_r      <= OWN_NONE;
          lat_we_r     <= 1'b0;
          mem_en_r     <= 1'b0;
          mem_we_r     <= 1'b0;
          mem_addr_r   <= '0;
          mem_wdata_r  <= '0;
          core_ready_r <= 1'b0;
          load_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en     = mem_en_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign owner      = owner_r;
  assign core_ready = core_ready_r;
  assign load_ready = load_ready_r;
  // Read data is only returned to the owner of a read, in its ready cycle
  assign core_rdata = (core_ready_r && !lat_we_r) ? mem_rdata : '0;
  assign load_rdata = (load_ready_r && !lat_we_r) ? mem_rdata : '0;

endmodule
